// File: rtl/uart_tx_scheduler_if.sv
// Signal bundle between the packet formatters, the scheduler and the Uart.
// Handshakes:
//   reqX_valid/reqX_data: the requester holds valid and data until it sees
//     reqX_ready high; ready is a one-cycle registered pulse in the cycle after
//     the edge that captured the byte, so the requester may move on at once.
//   uart_start/uart_data: start is a level held with stable data until the Uart
//     reports uart_done, which is sampled high on a clock edge.
interface uart_tx_scheduler_if;
  logic       req0_valid;
  logic [7:0] req0_data;
  logic       req0_ready;
  logic       req1_valid;
  logic [7:0] req1_data;
  logic       req1_ready;
  logic       uart_start;
  logic [7:0] uart_data;
  logic       uart_done;
  logic [1:0] grant;
  logic       busy;
  logic       abort;
  logic [1:0] state;

  modport master (
    output req0_valid, req0_data, req1_valid, req1_data, uart_done,
    input  req0_ready, req1_ready, uart_start, uart_data, grant, busy, abort, state
  );

  modport slave (
    input  req0_valid, req0_data, req1_valid, req1_data, uart_done,
    output req0_ready, req1_ready, uart_start, uart_data, grant, busy, abort, state
  );
endinterface

// File: rtl/uart_tx_scheduler.sv
// Packet-granular round-robin sharing of one UART transmitter between two
// byte-stream requesters, with an inter-byte idle gap and a mid-packet timeout.
module uart_tx_scheduler #(
    parameter int unsigned GAP_CYCLES     = 1000,
    parameter int unsigned TIMEOUT_CYCLES = 100000,
    parameter logic [7:0]  EOP_BYTE       = 8'h0A
) (
    input logic           clock,
    input logic           reset,
    uart_tx_scheduler_if.slave bus
);

    localparam int GAP_W = $clog2(GAP_CYCLES) + 1;
    localparam int TMO_W = $clog2(TIMEOUT_CYCLES) + 1;

    typedef enum logic [1:0] {
        IDLE      = 2'd0,
        WAIT_DONE = 2'd1,
        GAP       = 2'd2,
        HOLD      = 2'd3
    } state_t;

    state_t           state_q;
    logic [7:0]       data_q;
    logic             start_q;
    logic             ready0_q;
    logic             ready1_q;
    logic             abort_q;
    logic             busy_q;
    logic             rr_q;      // 1 = req1 is favoured on contention
    logic [1:0]       grant_q;
    logic [GAP_W-1:0] gap_q;
    logic [TMO_W-1:0] tmo_q;

    logic pick1;
    logic hold_valid;
    logic last_eop;
    logic gap_expire;

    assign pick1      = bus.req1_valid && (!bus.req0_valid || rr_q);
    assign hold_valid = grant_q[0] ? bus.req0_valid : bus.req1_valid;
    assign last_eop   = (data_q == EOP_BYTE);
    // With no gap configured, the done edge itself acts as the gap expiry.
    assign gap_expire = ((state_q == GAP) && (gap_q == GAP_W'(1))) ||
                        ((state_q == WAIT_DONE) && bus.uart_done && (GAP_CYCLES == 0));

    always_ff @(posedge clock) begin
        if (!reset) begin
            state_q  <= IDLE;
            data_q   <= 8'h00;
            start_q  <= 1'b0;
            ready0_q <= 1'b0;
            ready1_q <= 1'b0;
            abort_q  <= 1'b0;
            busy_q   <= 1'b0;
            rr_q     <= 1'b0;
            grant_q  <= 2'b00;
            gap_q    <= '0;
            tmo_q    <= '0;
        end else begin
            ready0_q <= 1'b0;
            ready1_q <= 1'b0;
            abort_q  <= 1'b0;
            case (state_q)
                IDLE: begin
                    if (bus.req0_valid || bus.req1_valid) begin
                        start_q <= 1'b1;
                        busy_q  <= 1'b1;
                        state_q <= WAIT_DONE;
                        if (pick1) begin
                            ready1_q <= 1'b1;
                            data_q   <= bus.req1_data;
                            grant_q  <= 2'b10;
                        end else begin
                            ready0_q <= 1'b1;
                            data_q   <= bus.req0_data;
                            grant_q  <= 2'b01;
                        end
                    end
                end
                WAIT_DONE: begin
                    if (bus.uart_done) begin
                        start_q <= 1'b0;
                        gap_q   <= GAP_W'(GAP_CYCLES);
                        state_q <= GAP;
                    end
                end
                GAP: begin
                    gap_q <= gap_q - GAP_W'(1);
                end
                HOLD: begin
                    if (hold_valid) begin
                        start_q <= 1'b1;
                        state_q <= WAIT_DONE;
                        if (grant_q[0]) begin
                            ready0_q <= 1'b1;
                            data_q   <= bus.req0_data;
                        end else begin
                            ready1_q <= 1'b1;
                            data_q   <= bus.req1_data;
                        end
                    end else if (tmo_q == TMO_W'(TIMEOUT_CYCLES - 1)) begin
                        // Stalled owner: drop the rest of its packet and hand over.
                        abort_q <= 1'b1;
                        grant_q <= 2'b00;
                        rr_q    <= grant_q[0];
                        busy_q  <= 1'b0;
                        state_q <= IDLE;
                    end else begin
                        tmo_q <= tmo_q + TMO_W'(1);
                    end
                end
                default: state_q <= IDLE;
            endcase

            if (gap_expire) begin
                if (last_eop) begin
                    grant_q <= 2'b00;
                    rr_q    <= grant_q[0];
                    busy_q  <= 1'b0;
                    state_q <= IDLE;
                end else begin
                    tmo_q   <= '0;
                    state_q <= HOLD;
                end
            end
        end
    end

    assign bus.req0_ready = ready0_q;
    assign bus.req1_ready = ready1_q;
    assign bus.uart_start = start_q;
    assign bus.uart_data  = data_q;
    assign bus.grant      = grant_q;
    assign bus.busy       = busy_q;
    assign bus.abort      = abort_q;
    assign bus.state      = state_q;

endmodule

// File: tb/tb_uart_tx_scheduler.sv
// Directed bench for uart_tx_scheduler: one instance with a 4-cycle gap and one
// with no gap, each driven by a Uart model that answers 10 cycles after start.
module tb_uart_tx_scheduler;

  localparam int GAP = 4;
  localparam int TMO = 20;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  uart_tx_scheduler_if bus ();
  uart_tx_scheduler_if bus0 ();

  uart_tx_scheduler #(.GAP_CYCLES(GAP), .TIMEOUT_CYCLES(TMO), .EOP_BYTE(8'h0A)) dut (
    .clock (clk),
    .reset (rst_n),
    .bus   (bus.slave)
  );

  uart_tx_scheduler #(.GAP_CYCLES(0), .TIMEOUT_CYCLES(TMO), .EOP_BYTE(8'h0A)) dut0 (
    .clock (clk),
    .reset (rst_n),
    .bus   (bus0.slave)
  );

  int n_checks = 0;
  int n_pass = 0;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs === exp) n_pass++;
    else $display("FAIL %s: got 0x%0h, want 0x%0h", tag, obs, exp);
  endtask

  // Uart models
  logic m_done, m0_done, extra_done;
  int m_cnt, m0_cnt;
  logic m_prev, m0_prev;
  assign bus.uart_done  = m_done | extra_done;
  assign bus0.uart_done = m0_done;

  always @(negedge clk) begin
    if (!rst_n) begin
      m_cnt = 0; m_done = 1'b0; m_prev = 1'b0;
      m0_cnt = 0; m0_done = 1'b0; m0_prev = 1'b0;
    end else begin
      m_done = 1'b0;
      if (m_cnt != 0) begin
        m_cnt--;
        if (m_cnt == 0) m_done = 1'b1;
      end else if (bus.uart_start && !m_prev) m_cnt = 10;
      m_prev = bus.uart_start;
      m0_done = 1'b0;
      if (m0_cnt != 0) begin
        m0_cnt--;
        if (m0_cnt == 0) m0_done = 1'b1;
      end else if (bus0.uart_start && !m0_prev) m0_cnt = 10;
      m0_prev = bus0.uart_start;
    end
  end

  // Scoreboards: expected byte order on each Uart
  logic [7:0] exp_q[$];
  logic [7:0] exp0_q[$];
  logic mon_prev = 1'b0, mon0_prev = 1'b0;
  logic chk_gap = 1'b0, had_fall = 1'b0, had_fall0 = 1'b0;
  int low_cnt = 0, low0_cnt = 0, rdy0_cnt = 0;

  always @(negedge clk) begin
    if (bus.req0_ready) rdy0_cnt++;
    if (bus.uart_start && !mon_prev) begin
      if (exp_q.size() == 0) check("extra_byte", 32'(exp_q.size()), 1);
      else check("uart_data", bus.uart_data, exp_q.pop_front());
      if (chk_gap && had_fall) check("gap_len", low_cnt, GAP + 1);
    end
    if (!bus.uart_start && mon_prev) begin had_fall = 1'b1; low_cnt = 0; end
    if (!bus.uart_start) low_cnt++;
    mon_prev = bus.uart_start;

    if (bus0.uart_start && !mon0_prev) begin
      if (exp0_q.size() == 0) check("extra_byte0", 32'(exp0_q.size()), 1);
      else check("uart_data0", bus0.uart_data, exp0_q.pop_front());
      if (had_fall0) check("gap0_len", low0_cnt, 1);
    end
    if (!bus0.uart_start && mon0_prev) begin had_fall0 = 1'b1; low0_cnt = 0; end
    if (!bus0.uart_start) low0_cnt++;
    mon0_prev = bus0.uart_start;
  end

  // Driver tasks: r=0/1 are the requesters of dut, r=2 is req0 of dut0
  task automatic set_req(input int r, input logic v, input logic [7:0] d);
    case (r)
      0: begin bus.req0_valid = v; bus.req0_data = d; end
      1: begin bus.req1_valid = v; bus.req1_data = d; end
      default: begin bus0.req0_valid = v; bus0.req0_data = d; end
    endcase
  endtask

  function automatic logic get_ready(input int r);
    case (r)
      0: return bus.req0_ready;
      1: return bus.req1_ready;
      default: return bus0.req0_ready;
    endcase
  endfunction

  task automatic wait_ready(input int r);
    int n = 0;
    do begin
      @(negedge clk);
      n++;
    end while (!get_ready(r) && n < 400);
    if (n >= 400) check($sformatf("ready%0d_timeout", r), 0, 1);
    set_req(r, 1'b0, 8'h00);
  endtask

  task automatic push_byte(input int r, input logic [7:0] b);
    @(negedge clk);
    set_req(r, 1'b1, b);
    wait_ready(r);
  endtask

  task automatic wait_idle();
    int n = 0;
    do begin
      @(negedge clk);
      n++;
    end while (bus.busy && n < 400);
    if (n >= 400) check("idle_timeout", 0, 1);
  endtask

  task automatic wait_hold();
    int n = 0;
    while (bus.state != 2'd3 && n < 100) begin
      @(negedge clk);
      n++;
    end
    if (n >= 100) check("hold_timeout", 0, 1);
  endtask

  task automatic do_reset();
    @(negedge clk);
    rst_n = 1'b0;
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
  endtask

  initial begin
    #300000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int n;
    extra_done = 1'b0;
    set_req(0, 1'b0, 8'h00);
    set_req(1, 1'b0, 8'h00);
    set_req(2, 1'b0, 8'h00);

    // Reset state
    repeat (3) @(negedge clk);
    check("rst_start", bus.uart_start, 0);
    check("rst_data", bus.uart_data, 0);
    check("rst_grant", bus.grant, 0);
    check("rst_busy", bus.busy, 0);
    check("rst_abort", bus.abort, 0);
    check("rst_ready", {bus.req0_ready, bus.req1_ready}, 0);
    rst_n = 1'b1;

    // 1. Single packet "C3+\n" from req0
    exp_q = '{8'h43, 8'h33, 8'h2B, 8'h0A};
    chk_gap = 1'b1; had_fall = 1'b0; rdy0_cnt = 0;
    push_byte(0, 8'h43); check("t1_grant_b0", bus.grant, 2'b01);
    push_byte(0, 8'h33); check("t1_grant_b1", bus.grant, 2'b01);
    push_byte(0, 8'h2B); check("t1_grant_b2", bus.grant, 2'b01);
    push_byte(0, 8'h0A); check("t1_grant_b3", bus.grant, 2'b01);
    wait_idle();
    chk_gap = 1'b0;
    check("t1_grant_rel", bus.grant, 2'b00);
    check("t1_ready_cnt", rdy0_cnt, 4);

    // 2. Contention out of reset, then again with req0 favoured
    do_reset();
    exp_q = '{8'h4D, 8'h0A, 8'h53, 8'h0A};
    fork
      begin push_byte(0, 8'h4D); push_byte(0, 8'h0A); end
      begin push_byte(1, 8'h53); check("t2_grant_r1", bus.grant, 2'b10); push_byte(1, 8'h0A); end
    join
    wait_idle();
    exp_q = '{8'h61, 8'h0A, 8'h62, 8'h0A};
    fork
      begin push_byte(0, 8'h61); push_byte(0, 8'h0A); end
      begin push_byte(1, 8'h62); push_byte(1, 8'h0A); end
    join
    wait_idle();
    check("t2_q_empty", exp_q.size(), 0);

    // 3. Lock hold: req1 ignored while req0 owns the packet
    exp_q = '{8'h50, 8'h0A, 8'h77, 8'h0A};
    push_byte(0, 8'h50);
    wait_hold();
    set_req(1, 1'b1, 8'h77);
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      check("t3_r1_ready", bus.req1_ready, 0);
      check("t3_grant", bus.grant, 2'b01);
    end
    push_byte(0, 8'h0A);
    wait_ready(1);
    push_byte(1, 8'h0A);
    wait_idle();
    check("t3_q_empty", exp_q.size(), 0);

    // 4. Timeout after "A" with req1 pending
    exp_q = '{8'h41, 8'h78, 8'h0A};
    push_byte(0, 8'h41);
    set_req(1, 1'b1, 8'h78);
    wait_hold();
    n = 0;
    while (!bus.abort && n < 100) begin
      @(negedge clk);
      n++;
    end
    check("t4_abort_delay", n, TMO);
    check("t4_grant_abort", bus.grant, 2'b00);
    @(negedge clk);
    check("t4_abort_pulse", bus.abort, 0);
    check("t4_grant_r1", bus.grant, 2'b10);
    check("t4_r1_ready", bus.req1_ready, 1);
    set_req(1, 1'b0, 8'h00);
    push_byte(1, 8'h0A);
    wait_idle();
    check("t4_q_empty", exp_q.size(), 0);

    // 5. Reset mid-byte; pointer was favouring req1 beforehand
    exp_q = '{8'h0A, 8'h55};
    push_byte(0, 8'h0A);
    wait_idle();
    push_byte(0, 8'h55);
    repeat (3) @(negedge clk);
    rst_n = 1'b0;
    @(negedge clk);
    check("t5_start", bus.uart_start, 0);
    check("t5_grant", bus.grant, 0);
    check("t5_busy", bus.busy, 0);
    rst_n = 1'b1;
    @(negedge clk);
    extra_done = 1'b1;
    @(negedge clk);
    extra_done = 1'b0;
    @(negedge clk);
    check("t5_late_start", bus.uart_start, 0);
    check("t5_late_busy", bus.busy, 0);
    exp_q = '{8'h30, 8'h0A, 8'h31, 8'h0A};
    fork
      begin push_byte(0, 8'h30); check("t5_grant_r0", bus.grant, 2'b01); push_byte(0, 8'h0A); end
      begin push_byte(1, 8'h31); push_byte(1, 8'h0A); end
    join
    wait_idle();
    check("t5_q_empty", exp_q.size(), 0);

    // 6. No gap: start re-rises one cycle after the first uart_done
    exp0_q = '{8'h21, 8'h0A};
    had_fall0 = 1'b0;
    push_byte(2, 8'h21);
    push_byte(2, 8'h0A);
    n = 0;
    do begin
      @(negedge clk);
      n++;
    end while (bus0.busy && n < 400);
    check("t6_grant_rel", bus0.grant, 2'b00);
    check("t6_q_empty", exp0_q.size(), 0);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
